// File: rtl/adc_rx_pkg.sv
// adc_rx_pkg: state encoding, default frame geometry and frame-length helper for the ADC receiver
package adc_rx_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, CONV = 2'b01, QUIET = 2'b10} state_t;
   localparam int N_DEF    = 12;
   localparam int LEAD_DEF = 4;
   localparam int DIV_DEF  = 4;
   function automatic int frame_len(input int lead, input int n);
      return lead + n;
   endfunction
endpackage

// File: rtl/sclk_tick_gen.sv
// sclk_tick_gen: SCLK half-period timer, strobes the Clock cycle on which SCLK must fall or rise
module sclk_tick_gen #(
   parameter int DIV = 4
) (
   input  logic Clock,
   input  logic reset,
   input  logic i_en,
   input  logic i_sclk,
   output logic o_toggle_fall,
   output logic o_toggle_rise
);
   localparam int CW = $clog2(DIV);
   logic [CW-1:0] r_cnt;
   logic          w_tick;
   assign w_tick        = i_en && (r_cnt == CW'(DIV - 1));
   assign o_toggle_fall = w_tick && i_sclk;
   assign o_toggle_rise = w_tick && !i_sclk;
   // half-period counter, held at zero outside CONV so every frame starts phase-aligned
   always_ff @(posedge Clock or posedge reset)
      if (reset) r_cnt <= '0;
      else r_cnt <= (!i_en || w_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/protocolo_adc_rx.sv
// protocolo_adc_rx: SPI-style 12-bit ADC capture master (Sync/SCLK generation, MSB-first shift-in); ADC_ZERO_CHECK_EN adds frame_err
module protocolo_adc_rx
   import adc_rx_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int LEAD = LEAD_DEF,
   parameter int DIV  = DIV_DEF
) (
   input  logic         Clock,
   input  logic         reset,
   input  logic         start,
   input  logic         Data_ADC,
   output logic         Sync,
   output logic         SCLK,
   output logic [N-1:0] data_Out,
   output logic         data_valid,
   output logic         busy
`ifdef ADC_ZERO_CHECK_EN
   ,
   output logic         frame_err
`endif
);
   localparam int F  = frame_len(LEAD, N);
   localparam int BW = $clog2(F + 1);
   localparam int QW = $clog2(2 * DIV);
   state_t        r_state, w_next;
   logic [BW-1:0] r_bits;
   logic [N-1:0]  r_shift;
   logic [QW-1:0] r_quiet;
   logic          w_fall, w_rise, w_last, w_done, w_begin, w_quiet_done;
   assign w_last       = r_bits == BW'(F);
   assign w_done       = w_fall && w_last;
   assign w_begin      = (r_state == IDLE) && start;
   assign w_quiet_done = r_quiet == QW'(2 * DIV - 1);
   assign busy         = r_state != IDLE;
   sclk_tick_gen #(.DIV(DIV)) u_tick (
      .Clock        (Clock),
      .reset        (reset),
      .i_en         (r_state == CONV),
      .i_sclk       (SCLK),
      .o_toggle_fall(w_fall),
      .o_toggle_rise(w_rise)
   );
   // state register
   always_ff @(posedge Clock or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   // next state: one frame per start sampled in IDLE, then the ADC quiet time
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? CONV : IDLE;
         CONV:    w_next = w_done ? QUIET : CONV;
         QUIET:   w_next = w_quiet_done ? IDLE : QUIET;
         default: w_next = IDLE;
      endcase
   end
   // pin timing: Sync falls on frame start, SCLK holds high after the last rising edge until Sync rises
   always_ff @(posedge Clock or posedge reset)
      if (reset) begin
         Sync <= 1'b1;
         SCLK <= 1'b1;
      end else begin
         Sync <= w_begin ? 1'b0 : (w_done ? 1'b1 : Sync);
         SCLK <= (w_rise || (w_fall && !w_last)) ? ~SCLK : SCLK;
      end
   // capture: count rising edges, drop the leading bits, shift the rest in MSB first
   always_ff @(posedge Clock or posedge reset)
      if (reset) begin
         r_bits  <= '0;
         r_shift <= '0;
      end else if (w_begin) begin
         r_bits  <= '0;
         r_shift <= '0;
      end else if (w_rise) begin
         r_bits  <= r_bits + 1'b1;
         r_shift <= (r_bits >= BW'(LEAD)) ? {r_shift[N-2:0], Data_ADC} : r_shift;
      end
   // quiet-time counter, restarted for every frame
   always_ff @(posedge Clock or posedge reset)
      if (reset) r_quiet <= '0;
      else r_quiet <= (r_state == QUIET && !w_quiet_done) ? r_quiet + 1'b1 : '0;
   // output sample and its one-cycle valid strobe
   always_ff @(posedge Clock or posedge reset)
      if (reset) begin
         data_Out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= w_done;
         data_Out   <= w_done ? r_shift : data_Out;
      end
`ifdef ADC_ZERO_CHECK_EN
   logic r_lead_err;
   // any leading bit read as 1 flags misalignment; published alongside data_valid
   always_ff @(posedge Clock or posedge reset)
      if (reset) begin
         r_lead_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         r_lead_err <= w_begin ? 1'b0 : (r_lead_err | (w_rise && (r_bits < BW'(LEAD)) && Data_ADC));
         frame_err  <= w_done ? r_lead_err : frame_err;
      end
`endif
endmodule

// File: tb/tb_protocolo_adc_rx.sv
// tb_protocolo_adc_rx: directed bench for the ADC receiver (DIV=2 main instance, DIV=4 timing instance)
module tb_protocolo_adc_rx;
   logic        Clock = 1'b0, reset = 1'b1, start = 1'b0, Data_ADC = 1'b0;
   logic        Sync, SCLK, data_valid, busy;
   logic [11:0] data_Out;
   logic        start4 = 1'b0, Data4 = 1'b0;
   logic        Sync4, SCLK4, data_valid4, busy4;
   logic [11:0] data_Out4;
`ifdef ADC_ZERO_CHECK_EN
   logic        frame_err;
`endif
   int          checks = 0, failures = 0;
   logic [15:0] wq [0:3];
   int          wi = 0, idx = 15, idx4 = 15;
   logic [15:0] cur = 16'h0, w4 = 16'h0C3A;

   always #5 Clock = ~Clock;

   protocolo_adc_rx #(.N(12), .LEAD(4), .DIV(2)) dut (
      .Clock(Clock), .reset(reset), .start(start), .Data_ADC(Data_ADC),
      .Sync(Sync), .SCLK(SCLK), .data_Out(data_Out), .data_valid(data_valid), .busy(busy)
`ifdef ADC_ZERO_CHECK_EN
      , .frame_err(frame_err)
`endif
   );

`ifdef ADC_ZERO_CHECK_EN
   logic frame_err4;
`endif
   protocolo_adc_rx #(.N(12), .LEAD(4), .DIV(4)) dut4 (
      .Clock(Clock), .reset(reset), .start(start4), .Data_ADC(Data4),
      .Sync(Sync4), .SCLK(SCLK4), .data_Out(data_Out4), .data_valid(data_valid4), .busy(busy4)
`ifdef ADC_ZERO_CHECK_EN
      , .frame_err(frame_err4)
`endif
   );

   // ADC models: load a word on Sync fall, drive the next bit MSB first on each SCLK fall
   always @(negedge Sync) begin
      cur = wq[wi % 4];
      wi = wi + 1;
      idx = 15;
      Data_ADC = 1'b0;
   end
   always @(negedge SCLK) if (!Sync && idx >= 0) begin
      Data_ADC = cur[idx];
      idx = idx - 1;
   end
   always @(negedge Sync4) begin
      idx4 = 15;
      Data4 = 1'b0;
   end
   always @(negedge SCLK4) if (!Sync4 && idx4 >= 0) begin
      Data4 = w4[idx4];
      idx4 = idx4 - 1;
   end

   task automatic pulse_start();
      @(negedge Clock);
      start = 1'b1;
      @(negedge Clock);
      start = 1'b0;
   endtask

   // observes one frame from the negedge after CONV entry until busy drops
   task automatic measure(output int sync_low, output int falls, output int dvs,
                          output int dv_to_idle, output logic [11:0] dv_data, output bit tmo);
      int   dv_at;
      logic ps;
      sync_low = 0; falls = 0; dvs = 0; dv_to_idle = -1; dv_data = '0; tmo = 1'b1; dv_at = -1; ps = SCLK;
      for (int c = 0; c < 400; c++) begin
         if (!Sync) sync_low++;
         if (ps && !SCLK) falls++;
         ps = SCLK;
         if (data_valid) begin dvs++; dv_data = data_Out; dv_at = c; end
         if (!busy) begin dv_to_idle = c - dv_at; tmo = 1'b0; break; end
         @(negedge Clock);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge Clock);
      checks++; if (Sync !== 1'b1) begin failures++; $display("FAIL rst_sync got=%b exp=1", Sync); end
      checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL rst_sclk got=%b exp=1", SCLK); end
      checks++; if (data_Out !== 12'h000) begin failures++; $display("FAIL rst_data got=%h exp=000", data_Out); end
      checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      reset = 1'b0;
      repeat (3) @(negedge Clock);
      checks++; if ({Sync, SCLK, busy, Sync4, SCLK4, busy4} !== 6'b110110) begin failures++; $display("FAIL rst_idle got=%b exp=110110", {Sync, SCLK, busy, Sync4, SCLK4, busy4}); end
   endtask

   task automatic test_reset_mid_frame();
      int sl, fl, dv, gap, rises, dvs; logic [11:0] d; bit tmo; logic ps;
      wq[0] = 16'hFFFF; wq[1] = 16'h0ABC; wi = 0;
      pulse_start();
      rises = 0; ps = SCLK;
      for (int c = 0; c < 100 && rises < 8; c++) begin
         @(negedge Clock);
         if (!ps && SCLK) rises++;
         ps = SCLK;
      end
      checks++; if (rises !== 8) begin failures++; $display("FAIL mid_rises got=%0d exp=8", rises); end
      reset = 1'b1;
      #1;
      checks++; if ({Sync, SCLK, busy} !== 3'b110) begin failures++; $display("FAIL mid_abort got=%b exp=110", {Sync, SCLK, busy}); end
      checks++; if ({data_Out, data_valid} !== 13'h0) begin failures++; $display("FAIL mid_data got=%h exp=0", {data_Out, data_valid}); end
      @(negedge Clock);
      reset = 1'b0;
      dvs = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge Clock);
         if (data_valid || !Sync || busy) dvs++;
      end
      checks++; if (dvs !== 0) begin failures++; $display("FAIL mid_quiet_after got=%0d exp=0", dvs); end
      checks++; if (data_Out !== 12'h000) begin failures++; $display("FAIL mid_hold got=%h exp=000", data_Out); end
      wi = 1;
      pulse_start();
      measure(sl, fl, dv, gap, d, tmo);
      checks++; if (tmo !== 1'b0 || dv !== 1) begin failures++; $display("FAIL mid_next_valid got=%0d tmo=%b exp=1", dv, tmo); end
      checks++; if (d !== 12'hABC) begin failures++; $display("FAIL mid_next_data got=%h exp=abc", d); end
   endtask

   task automatic test_single();
      int sl, fl, dv, gap; logic [11:0] d; bit tmo;
      wq[0] = 16'h0A5C; wi = 0;
      pulse_start();
      measure(sl, fl, dv, gap, d, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", tmo); end
      checks++; if (sl !== 66) begin failures++; $display("FAIL single_sync_low got=%0d exp=66", sl); end
      checks++; if (fl !== 16) begin failures++; $display("FAIL single_sclk_periods got=%0d exp=16", fl); end
      checks++; if (dv !== 1) begin failures++; $display("FAIL single_valid_cycles got=%0d exp=1", dv); end
      checks++; if (d !== 12'hA5C) begin failures++; $display("FAIL single_data got=%h exp=a5c", d); end
      checks++; if (gap !== 4) begin failures++; $display("FAIL single_valid_to_idle got=%0d exp=4", gap); end
      repeat (5) @(negedge Clock);
      checks++; if ({data_Out, data_valid, Sync, SCLK} !== {12'hA5C, 3'b011}) begin failures++; $display("FAIL single_hold got=%h exp=%h", {data_Out, data_valid, Sync, SCLK}, {12'hA5C, 3'b011}); end
   endtask

   task automatic test_back_to_back();
      int n_dv, hi, dv_c [0:1]; logic [11:0] dv_d [0:1]; bit gap_done;
      wq[0] = 16'h0FFF; wq[1] = 16'h0000; wi = 0;
      n_dv = 0; hi = 0; gap_done = 1'b0; dv_c[0] = 0; dv_c[1] = 0; dv_d[0] = '0; dv_d[1] = '1;
      @(negedge Clock);
      start = 1'b1;
      for (int c = 0; c < 400 && n_dv < 2; c++) begin
         @(negedge Clock);
         if (data_valid) begin dv_c[n_dv] = c; dv_d[n_dv] = data_Out; n_dv++; end
         if (n_dv == 1 && !gap_done) begin if (Sync) hi++; else gap_done = 1'b1; end
      end
      start = 1'b0;
      checks++; if (n_dv !== 2) begin failures++; $display("FAIL b2b_frames got=%0d exp=2", n_dv); end
      checks++; if (dv_d[0] !== 12'hFFF) begin failures++; $display("FAIL b2b_data0 got=%h exp=fff", dv_d[0]); end
      checks++; if (dv_d[1] !== 12'h000) begin failures++; $display("FAIL b2b_data1 got=%h exp=000", dv_d[1]); end
      checks++; if (dv_c[1] - dv_c[0] !== 71) begin failures++; $display("FAIL b2b_period got=%0d exp=71", dv_c[1] - dv_c[0]); end
      checks++; if (hi !== 5) begin failures++; $display("FAIL b2b_sync_high got=%0d exp=5", hi); end
      for (int c = 0; c < 50 && busy; c++) @(negedge Clock);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
   endtask

   task automatic test_start_ignored();
      int dvs, sl, dv_at; logic [11:0] d;
      wq[0] = 16'h0321; wq[1] = 16'h0FFF; wi = 0;
      dvs = 0; sl = 0; dv_at = -10; d = '0;
      pulse_start();
      for (int c = 0; c < 200; c++) begin
         if (!Sync) sl++;
         if (data_valid) begin dvs++; d = data_Out; dv_at = c; end
         start = (c == 20) || (c == dv_at + 1);
         @(negedge Clock);
      end
      start = 1'b0;
      checks++; if (dvs !== 1) begin failures++; $display("FAIL ign_valid_count got=%0d exp=1", dvs); end
      checks++; if (sl !== 66) begin failures++; $display("FAIL ign_sync_low got=%0d exp=66", sl); end
      checks++; if ({d, busy} !== {12'h321, 1'b0}) begin failures++; $display("FAIL ign_data got=%h exp=%h", {d, busy}, {12'h321, 1'b0}); end
   endtask

`ifdef ADC_ZERO_CHECK_EN
   task automatic test_zero_check();
      int sl, fl, dv, gap; logic [11:0] d; bit tmo;
      wq[0] = 16'h8123; wq[1] = 16'h0123; wi = 0;
      pulse_start();
      measure(sl, fl, dv, gap, d, tmo);
      checks++; if ({d, frame_err} !== {12'h123, 1'b1}) begin failures++; $display("FAIL zc_err_frame got=%h exp=%h", {d, frame_err}, {12'h123, 1'b1}); end
      pulse_start();
      measure(sl, fl, dv, gap, d, tmo);
      checks++; if ({d, frame_err} !== {12'h123, 1'b0}) begin failures++; $display("FAIL zc_clean_frame got=%h exp=%h", {d, frame_err}, {12'h123, 1'b0}); end
   endtask
`endif

   task automatic test_div4();
      int low, runs, bad, run, dv; logic lvl; logic [11:0] d;
      low = 0; runs = 0; bad = 0; run = 0; dv = 0; lvl = 1'b1; d = '0;
      @(negedge Clock);
      start4 = 1'b1;
      @(negedge Clock);
      start4 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!Sync4) begin
            low++;
            if (SCLK4 == lvl) run++;
            else begin runs++; if (run != 4) bad++; run = 1; lvl = SCLK4; end
         end else if (low > 0 && run > 0) begin
            runs++; if (run != 4) bad++; run = 0;
         end
         if (data_valid4) begin dv++; d = data_Out4; end
         if (!busy4) break;
         @(negedge Clock);
      end
      checks++; if (low !== 132) begin failures++; $display("FAIL div4_sync_low got=%0d exp=132", low); end
      checks++; if (runs !== 33 || bad !== 0) begin failures++; $display("FAIL div4_half_periods runs=%0d bad=%0d exp runs=33 bad=0", runs, bad); end
      checks++; if (dv !== 1 || d !== 12'hC3A) begin failures++; $display("FAIL div4_data got=%0d/%h exp=1/c3a", dv, d); end
   endtask

   initial begin
      wq[0] = 16'h0; wq[1] = 16'h0; wq[2] = 16'h0; wq[3] = 16'h0;
      test_reset();
      test_reset_mid_frame();
      test_single();
      test_back_to_back();
      test_start_ignored();
`ifdef ADC_ZERO_CHECK_EN
      test_zero_check();
`endif
      test_div4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
